keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000; clk cycles per column dwell (1 kHz tick at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 20; consecutive stable ticks required to accept a press or release.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port row  input  4  keypad row lines; active-low, pulled up externally; asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive; active-low; exactly one bit low at all times.
REQ-007 SHALL have port key_code  output  4  hex value of the last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer; all row decisions use the synchronized value only.
REQ-011 SHALL run a dwell counter 0..SCAN_DIV-1; tick = counter at SCAN_DIV-1; counter wraps to 0 on the tick; width $clog2(SCAN_DIV).
REQ-012 SHALL hold col index c (0..3) and drive col = ~(1<<c); c changes only on a tick in state SCAN; 3 wraps to 0.
REQ-013 SHALL map (row r, col c) to key_code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D (c0..c3 left to right).
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, HELD, and evaluate rows only on ticks.
REQ-015 SCAN: on a tick with all synced rows high, advance c; on a tick with any row low, capture lowest-index low row as r, keep c, set stable count = 1, go DEBOUNCE.
REQ-016 Multiple rows low: lowest row index wins; other columns are not scanned until return to SCAN.
REQ-017 DEBOUNCE: col frozen; on a tick with row r low, increment count; on a tick with row r high, clear count, advance c, go SCAN.
REQ-018 DEBOUNCE: when count reaches DEBOUNCE_TICKS on a tick, key_code SHALL update and key_valid SHALL pulse high for exactly the following cycle; go HELD, clear count.
REQ-019 DEBOUNCE_TICKS = 1 SHALL accept on the detection tick itself, with no DEBOUNCE dwell.
REQ-020 HELD: key_held = 1; col frozen; on a tick with all rows of column c high, increment release count; on any row low, clear it.
REQ-021 HELD: when release count reaches DEBOUNCE_TICKS, key_held SHALL drop the next cycle; advance c, go SCAN.
REQ-022 key_code SHALL hold its value until the next acceptance; a repeated press of the same key SHALL pulse key_valid again.
REQ-023 No key_valid SHALL occur while in HELD, regardless of other keys pressed.

Reset
REQ-024 On rst: state SCAN, c = 0, col = 4'b1110, dwell counter 0, stable/release counts 0.
REQ-025 On rst: key_code = 4'h0, key_valid = 0, key_held = 0, synchronizer flops = 4'b1111.
REQ-026 rst asserted mid-DEBOUNCE or mid-HELD SHALL abort with no key_valid pulse; scanning restarts from c = 0.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-027 Idle, rows 4'b1111 -> col cycles 1110, 1101, 1011, 0111, 1110 every 4 clk; key_valid never asserts.
REQ-028 Press '5' (row1 low while col=1101), held -> col frozen at 1101; key_valid one cycle after 3rd stable tick; key_code = 4'h5; key_held = 1.
REQ-029 Press 'D' for only 2 ticks, then release -> no key_valid; scanning resumes at col = 1110.
REQ-030 After accepting '5', release for 3 ticks -> key_held = 0; scan resumes at 1011; press '5' again -> second key_valid, key_code = 4'h5.
REQ-031 Rows 0 and 2 both low on col0 -> key_code = 4'h1; bouncing row1 during HELD (release count 2 then low) -> key_held stays 1.
REQ-032 rst pulse during DEBOUNCE of 'A' -> outputs at reset values next cycle; col = 1110; no key_valid.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
//
// Drives one keypad column low at a time. It dwells SCAN_DIV clocks per column and evaluates
// the synchronized rows once per dwell (a "tick"). When a key press stays stable for
// DEBOUNCE_TICKS ticks, the scanner reports that key. It then holds the column until the key
// has been released for the same number of ticks.
//
// Parameters:
//   SCAN_DIV       clk cycles per column dwell
//   DEBOUNCE_TICKS consecutive stable ticks needed to accept a press or a release
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, exactly one bit low
//   key_code   hex value of the last accepted key
//   key_valid  one-cycle pulse when a key is accepted
//   key_held   high while the accepted key remains pressed
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 100_000,
   parameter int unsigned DEBOUNCE_TICKS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DbW  = $clog2(DEBOUNCE_TICKS + 1);

   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
   // Count value seen on the tick that completes a debounce window
   localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE_TICKS - 1);

   localparam logic [1:0] StScan     = 2'd0;
   localparam logic [1:0] StDebounce = 2'd1;
   localparam logic [1:0] StHeld     = 2'd2;

   logic [3:0]      row_meta_q, row_sync_q;
   logic [CntW-1:0] div_q;
   logic            tick;
   logic [1:0]      state_q, state_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [1:0]      row_idx_q, row_idx_d;
   logic [DbW-1:0]  stable_q, stable_d;
   logic [DbW-1:0]  rel_q, rel_d;
   logic [3:0]      key_code_q, key_code_d;
   logic            key_valid_q, key_valid_d;
   logic            key_held_q, key_held_d;
   logic            any_low;
   logic [1:0]      low_row;
   logic            sel_row_low;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;
         4'h1: k = 4'h2;
         4'h2: k = 4'h3;
         4'h3: k = 4'hA;
         4'h4: k = 4'h4;
         4'h5: k = 4'h5;
         4'h6: k = 4'h6;
         4'h7: k = 4'hB;
         4'h8: k = 4'h7;
         4'h9: k = 4'h8;
         4'hA: k = 4'h9;
         4'hB: k = 4'hC;
         4'hC: k = 4'h0;
         4'hD: k = 4'hF;
         4'hE: k = 4'hE;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Row synchronizer resets to the idle (all released) level
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q <= 4'b1111;
         row_sync_q <= 4'b1111;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   assign tick = (div_q == CntMax);

   // Lowest-index low row wins when several rows are pressed
   always_comb begin
      any_low = (row_sync_q != 4'b1111);
      if (!row_sync_q[0]) begin
         low_row = 2'd0;
      end else if (!row_sync_q[1]) begin
         low_row = 2'd1;
      end else if (!row_sync_q[2]) begin
         low_row = 2'd2;
      end else begin
         low_row = 2'd3;
      end
   end

   assign sel_row_low = !row_sync_q[row_idx_q];

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      stable_d    = stable_q;
      rel_d       = rel_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      if (tick) begin
         case (state_q)
            StScan: begin
               if (!any_low) begin
                  col_idx_d = col_idx_q + 2'd1;
               end else begin
                  row_idx_d = low_row;
                  if (DEBOUNCE_TICKS <= 1) begin
                     // Single-tick debounce accepts on the detection tick itself
                     key_code_d  = key_map(low_row, col_idx_q);
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     stable_d    = '0;
                     rel_d       = '0;
                     state_d     = StHeld;
                  end else begin
                     stable_d = DbW'(1);
                     state_d  = StDebounce;
                  end
               end
            end
            StDebounce: begin
               if (sel_row_low) begin
                  if (stable_q == DbLast) begin
                     key_code_d  = key_map(row_idx_q, col_idx_q);
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     stable_d    = '0;
                     rel_d       = '0;
                     state_d     = StHeld;
                  end else begin
                     stable_d = stable_q + 1'b1;
                  end
               end else begin
                  stable_d  = '0;
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = StScan;
               end
            end
            StHeld: begin
               if (!any_low) begin
                  if (rel_q == DbLast) begin
                     rel_d      = '0;
                     key_held_d = 1'b0;
                     col_idx_d  = col_idx_q + 2'd1;
                     state_d    = StScan;
                  end else begin
                     rel_d = rel_q + 1'b1;
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: begin
               state_d  = StScan;
               stable_d = '0;
               rel_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StScan;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         stable_q    <= '0;
         rel_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         stable_q    <= stable_d;
         rel_q       <= rel_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign col       = ~(4'b0001 << col_idx_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_TICKS=3).
// A keypad model turns the set of pressed keys and the column drive into row levels.
// Expected key codes are queued by the stimulus and are popped by a monitor on key_valid.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed;  // bit r*4+c

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_q[$];
   logic       prev_valid = 1'b0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE_TICKS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .row(row),
      .col(col),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_held(key_held)
   );

   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
         end
      end
   end

   // Monitor: every key_valid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (key_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: key_code=%0h, no key expected", key_code);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (key_code !== e) begin
               bad++;
               $display("FAIL key_code_on_valid: got %0h expected %0h", key_code, e);
            end
         end
         total++;
         if (key_held !== 1'b1 || prev_valid) begin
            bad++;
            $display("FAIL valid_pulse_shape: held=%0b prev_valid=%0b expected held=1 prev=0",
                     key_held, prev_valid);
         end
      end
      prev_valid = key_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic wait_held(input logic v, input string name);
      int n = 0;
      while (key_held !== v && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, key_held}, {31'd0, v});
   endtask

   // Waits for the negedge just after col switches to target (the tick edge)
   task automatic wait_col_enter(input logic [3:0] target, input string name);
      logic [3:0] prev;
      int n = 0;
      prev = col;
      @(negedge clk);
      while (!(prev != target && col == target) && n < 100) begin
         prev = col;
         @(negedge clk);
         n++;
      end
      check(name, {28'd0, col}, {28'd0, target});
   endtask

   initial begin
      logic [3:0] seq [4];
      int n;
      seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      pressed = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_col", {28'd0, col}, 32'he);
      check("reset_code", {28'd0, key_code}, 32'h0);
      check("reset_valid", {31'd0, key_valid}, 32'h0);
      check("reset_held", {31'd0, key_held}, 32'h0);
      rst = 1'b0;

      // Idle scan: each column for 4 clocks, in order
      wait_col_enter(4'b1101, "idle_enter_col1");
      for (int i = 0; i < 16; i++) begin
         check("idle_col_seq", {28'd0, col}, {28'd0, seq[((i / 4) + 1) % 4]});
         @(negedge clk);
      end

      // Press '5' and hold
      exp_q.push_back(4'h5);
      pressed[1*4+1] = 1'b1;
      wait_held(1'b1, "press5_held");
      check("press5_code", {28'd0, key_code}, 32'h5);
      for (int i = 0; i < 5; i++) begin
         check("press5_col_frozen", {28'd0, col}, 32'hd);
         repeat (4) @(negedge clk);
      end

      // Release: three stable ticks, then scan resumes at the next column
      pressed = '0;
      n = 0;
      while (key_held && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n < 11 || n > 14) begin
         bad++;
         $display("FAIL release_latency: got %0d clocks expected 11..14", n);
      end
      check("release_col", {28'd0, col}, 32'hb);

      // Same key again gives a second acceptance
      exp_q.push_back(4'h5);
      pressed[1*4+1] = 1'b1;
      wait_held(1'b1, "repress5_held");
      check("repress5_code", {28'd0, key_code}, 32'h5);
      pressed = '0;
      wait_held(1'b0, "repress5_release");

      // 'D' seen on only two ticks: rejected, scanning resumes at col 0
      wait_col_enter(4'b0111, "d_enter_col3");
      pressed[3*4+3] = 1'b1;
      repeat (8) @(negedge clk);
      pressed = '0;
      n = 0;
      while (col == 4'b0111 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("d_reject_col", {28'd0, col}, 32'he);
      check("d_reject_held", {31'd0, key_held}, 32'h0);
      check("d_reject_code", {28'd0, key_code}, 32'h5);

      // Rows 0 and 2 on col 0: lowest row wins -> '1'
      exp_q.push_back(4'h1);
      pressed[0*4+0] = 1'b1;
      pressed[2*4+0] = 1'b1;
      wait_held(1'b1, "multi_held");
      check("multi_code", {28'd0, key_code}, 32'h1);
      // Bounce: released for exactly two ticks, then pressed again
      pressed = '0;
      repeat (8) @(negedge clk);
      pressed[0*4+0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bounce_held", {31'd0, key_held}, 32'h1);
         check("bounce_col", {28'd0, col}, 32'he);
         repeat (4) @(negedge clk);
      end
      pressed = '0;
      wait_held(1'b0, "multi_release");

      // Reset in the middle of debouncing 'A'
      wait_col_enter(4'b0111, "a_enter_col3");
      pressed[0*4+3] = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      pressed = '0;
      @(negedge clk);
      check("rst_mid_col", {28'd0, col}, 32'he);
      check("rst_mid_code", {28'd0, key_code}, 32'h0);
      check("rst_mid_valid", {31'd0, key_valid}, 32'h0);
      check("rst_mid_held", {31'd0, key_held}, 32'h0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      check("pending_expected", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
